// File: rtl/rob_multi.sv
// rob_multi: multi-issue reorder buffer.
//   Accepts up to DISP_W in-order dispatches per cycle (all-or-nothing), marks
//   entries done from CDB_PORTS completion ports, and retires up to COMMIT_W
//   done entries per cycle in program order. Retiring a mispredicted entry
//   squashes everything younger and pulses flush_o.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dispatch_*_i / _ready_o  dispatch lanes (packed from lane 0), ready when DISP_W entries free
//   alloc_tag_o              tag each dispatch lane would receive (tail + k)
//   cdb_*_i                  completion ports: valid, tag, mispredict
//   commit_*_o               registered retirement slots (packed from slot 0)
//   flush_o, flush_tag_o     registered one-cycle squash pulse and the offending tag
//   rob_empty_o, rob_count_o occupancy, combinational from state
module rob_multi #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned ROB_TAG_W = $clog2(ROB_DEPTH),
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned AREG_W    = 5,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned COMMIT_W  = 2,
    parameter int unsigned CDB_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DISP_W-1:0]             dispatch_valid_i,
    input  logic [DISP_W-1:0]             dispatch_has_rd_i,
    input  logic [DISP_W*AREG_W-1:0]      dispatch_rd_arch_i,
    input  logic [DISP_W*PREG_W-1:0]      dispatch_rd_phys_i,
    input  logic [DISP_W*PREG_W-1:0]      dispatch_rd_old_phys_i,
    output logic                          dispatch_ready_o,
    output logic [DISP_W*ROB_TAG_W-1:0]   alloc_tag_o,
    input  logic [CDB_PORTS-1:0]          cdb_valid_i,
    input  logic [CDB_PORTS*ROB_TAG_W-1:0] cdb_tag_i,
    input  logic [CDB_PORTS-1:0]          cdb_mispredict_i,
    output logic [COMMIT_W-1:0]           commit_valid_o,
    output logic [COMMIT_W-1:0]           commit_has_rd_o,
    output logic [COMMIT_W*AREG_W-1:0]    commit_rd_arch_o,
    output logic [COMMIT_W*PREG_W-1:0]    commit_rd_phys_o,
    output logic [COMMIT_W*PREG_W-1:0]    commit_old_preg_o,
    output logic                          flush_o,
    output logic [ROB_TAG_W-1:0]          flush_tag_o,
    output logic                          rob_empty_o,
    output logic [ROB_TAG_W:0]            rob_count_o
);

    localparam int unsigned CNT_W = ROB_TAG_W + 1;

    // Pointer / occupancy state
    logic [ROB_TAG_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0]     count_q;

    // Per-entry status flags (reset) and payload (no reset needed)
    logic [ROB_DEPTH-1:0] valid_q, done_q, mispred_q;
    logic [ROB_DEPTH-1:0] valid_n, done_n, mispred_n;
    logic [ROB_DEPTH-1:0] has_rd_q;
    logic [AREG_W-1:0]    rd_arch_q [ROB_DEPTH];
    logic [PREG_W-1:0]    rd_phys_q [ROB_DEPTH];
    logic [PREG_W-1:0]    old_phys_q[ROB_DEPTH];

    // Combinational selection results
    logic [COMMIT_W-1:0]        retire_c;
    logic [COMMIT_W-1:0]        commit_has_rd_c;
    logic [COMMIT_W*AREG_W-1:0] commit_rd_arch_c;
    logic [COMMIT_W*PREG_W-1:0] commit_rd_phys_c;
    logic [COMMIT_W*PREG_W-1:0] commit_old_preg_c;
    logic [CNT_W-1:0]           n_retire_c;
    logic [CNT_W-1:0]           n_disp_c;
    logic                       flush_c;
    logic [ROB_TAG_W-1:0]       flush_tag_c;
    logic                       accept_c;
    logic [DISP_W:0]            disp_ext_c;
    logic                       disp_packed_c;

    // Occupancy-derived outputs; ready deliberately ignores same-cycle retirement
    assign rob_count_o      = count_q;
    assign rob_empty_o      = (count_q == '0);
    assign dispatch_ready_o = (count_q <= CNT_W'(ROB_DEPTH - DISP_W));

    // Tags offered to each dispatch lane, contiguous modulo depth
    always_comb begin
        alloc_tag_o = '0;
        for (int k = 0; k < int'(DISP_W); k++) begin
            alloc_tag_o[k*ROB_TAG_W +: ROB_TAG_W] = tail_q + ROB_TAG_W'(k);
        end
    end

    // Lane count of this cycle's dispatch request
    always_comb begin
        n_disp_c = '0;
        for (int k = 0; k < int'(DISP_W); k++) begin
            if (dispatch_valid_i[k]) n_disp_c = n_disp_c + CNT_W'(1);
        end
    end

    // Retirement scan from head; stops at the first non-retiring slot or after a mispredict
    always_comb begin
        logic stop;
        logic [ROB_TAG_W-1:0] idx;
        stop              = 1'b0;
        idx               = '0;
        retire_c          = '0;
        n_retire_c        = '0;
        flush_c           = 1'b0;
        flush_tag_c       = '0;
        commit_has_rd_c   = '0;
        commit_rd_arch_c  = '0;
        commit_rd_phys_c  = '0;
        commit_old_preg_c = '0;
        for (int j = 0; j < int'(COMMIT_W); j++) begin
            idx = head_q + ROB_TAG_W'(j);
            if (!stop && (CNT_W'(j) < count_q) && valid_q[idx] && done_q[idx]) begin
                retire_c[j]                            = 1'b1;
                n_retire_c                             = n_retire_c + CNT_W'(1);
                commit_has_rd_c[j]                     = has_rd_q[idx];
                commit_rd_arch_c[j*AREG_W +: AREG_W]   = rd_arch_q[idx];
                commit_rd_phys_c[j*PREG_W +: PREG_W]   = rd_phys_q[idx];
                commit_old_preg_c[j*PREG_W +: PREG_W]  = old_phys_q[idx];
                if (mispred_q[idx]) begin
                    stop        = 1'b1;
                    flush_c     = 1'b1;
                    flush_tag_c = idx;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // A flush discards whatever dispatch was offered alongside it
    assign accept_c = dispatch_ready_o && (|dispatch_valid_i) && !flush_c;

    // Next status flags: completions, then retirement clears, then new allocations
    always_comb begin
        valid_n   = valid_q;
        done_n    = done_q;
        mispred_n = mispred_q;
        for (int p = 0; p < int'(CDB_PORTS); p++) begin
            if (cdb_valid_i[p] && valid_q[cdb_tag_i[p*ROB_TAG_W +: ROB_TAG_W]]) begin
                done_n[cdb_tag_i[p*ROB_TAG_W +: ROB_TAG_W]] = 1'b1;
                if (cdb_mispredict_i[p]) mispred_n[cdb_tag_i[p*ROB_TAG_W +: ROB_TAG_W]] = 1'b1;
            end
        end
        for (int j = 0; j < int'(COMMIT_W); j++) begin
            if (retire_c[j]) begin
                valid_n[head_q + ROB_TAG_W'(j)]   = 1'b0;
                done_n[head_q + ROB_TAG_W'(j)]    = 1'b0;
                mispred_n[head_q + ROB_TAG_W'(j)] = 1'b0;
            end
        end
        if (accept_c) begin
            for (int k = 0; k < int'(DISP_W); k++) begin
                if (dispatch_valid_i[k]) begin
                    valid_n[tail_q + ROB_TAG_W'(k)]   = 1'b1;
                    done_n[tail_q + ROB_TAG_W'(k)]    = 1'b0;
                    mispred_n[tail_q + ROB_TAG_W'(k)] = 1'b0;
                end
            end
        end
    end

    // Control state and registered commit/flush outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            valid_q           <= '0;
            done_q            <= '0;
            mispred_q         <= '0;
            commit_valid_o    <= '0;
            commit_has_rd_o   <= '0;
            commit_rd_arch_o  <= '0;
            commit_rd_phys_o  <= '0;
            commit_old_preg_o <= '0;
            flush_o           <= 1'b0;
            flush_tag_o       <= '0;
        end else begin
            commit_valid_o    <= retire_c;
            commit_has_rd_o   <= commit_has_rd_c;
            commit_rd_arch_o  <= commit_rd_arch_c;
            commit_rd_phys_o  <= commit_rd_phys_c;
            commit_old_preg_o <= commit_old_preg_c;
            flush_o           <= flush_c;
            if (flush_c) begin
                flush_tag_o <= flush_tag_c;
                valid_q     <= '0;
                done_q      <= '0;
                mispred_q   <= '0;
                head_q      <= flush_tag_c + ROB_TAG_W'(1);
                tail_q      <= flush_tag_c + ROB_TAG_W'(1);
                count_q     <= '0;
            end else begin
                valid_q   <= valid_n;
                done_q    <= done_n;
                mispred_q <= mispred_n;
                head_q    <= head_q + ROB_TAG_W'(n_retire_c);
                if (accept_c) begin
                    tail_q  <= tail_q + ROB_TAG_W'(n_disp_c);
                    count_q <= count_q + n_disp_c - n_retire_c;
                end else begin
                    count_q <= count_q - n_retire_c;
                end
            end
        end
    end

    // Entry payload written on allocation
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            for (int k = 0; k < int'(DISP_W); k++) begin
                if (dispatch_valid_i[k]) begin
                    has_rd_q[tail_q + ROB_TAG_W'(k)]   <= dispatch_has_rd_i[k];
                    rd_arch_q[tail_q + ROB_TAG_W'(k)]  <= dispatch_rd_arch_i[k*AREG_W +: AREG_W];
                    rd_phys_q[tail_q + ROB_TAG_W'(k)]  <= dispatch_rd_phys_i[k*PREG_W +: PREG_W];
                    old_phys_q[tail_q + ROB_TAG_W'(k)] <= dispatch_rd_old_phys_i[k*PREG_W +: PREG_W];
                end
            end
        end
    end

    // Dispatch lanes must be packed from lane 0 (all-ones-from-bit-0 pattern)
    assign disp_ext_c    = {1'b0, dispatch_valid_i};
    assign disp_packed_c = ((disp_ext_c & (disp_ext_c + (DISP_W+1)'(1))) == '0);

    assert property (@(posedge clk) disable iff (rst) disp_packed_c);

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed scenarios plus randomized traffic for rob_multi,
// checked every cycle against a queue-based model of in-order retirement.
module tb_rob_multi;

    localparam int DEPTH = 16;
    localparam int TW    = 4;
    localparam int DW    = 2;
    localparam int CW    = 2;
    localparam int NP    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dispatch_valid_i, dispatch_has_rd_i;
    logic [9:0]  dispatch_rd_arch_i;
    logic [11:0] dispatch_rd_phys_i, dispatch_rd_old_phys_i;
    logic        dispatch_ready_o;
    logic [7:0]  alloc_tag_o;
    logic [1:0]  cdb_valid_i, cdb_mispredict_i;
    logic [7:0]  cdb_tag_i;
    logic [1:0]  commit_valid_o, commit_has_rd_o;
    logic [9:0]  commit_rd_arch_o;
    logic [11:0] commit_rd_phys_o, commit_old_preg_o;
    logic        flush_o;
    logic [3:0]  flush_tag_o;
    logic        rob_empty_o;
    logic [4:0]  rob_count_o;

    rob_multi dut (
        .clk(clk), .rst(rst),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_has_rd_i(dispatch_has_rd_i),
        .dispatch_rd_arch_i(dispatch_rd_arch_i), .dispatch_rd_phys_i(dispatch_rd_phys_i),
        .dispatch_rd_old_phys_i(dispatch_rd_old_phys_i), .dispatch_ready_o(dispatch_ready_o),
        .alloc_tag_o(alloc_tag_o), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
        .cdb_mispredict_i(cdb_mispredict_i), .commit_valid_o(commit_valid_o),
        .commit_has_rd_o(commit_has_rd_o), .commit_rd_arch_o(commit_rd_arch_o),
        .commit_rd_phys_o(commit_rd_phys_o), .commit_old_preg_o(commit_old_preg_o),
        .flush_o(flush_o), .flush_tag_o(flush_tag_o), .rob_empty_o(rob_empty_o),
        .rob_count_o(rob_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: program-ordered queue of live entries
    typedef struct {
        int tag;
        bit has_rd;
        int arch;
        int phys;
        int old;
        bit done;
        bit mis;
    } ent_t;

    ent_t mq[$];
    int   m_tail = 0;

    // Deterministic lane payload derived from a base number
    task automatic pay(input int base);
        dispatch_has_rd_i      = 2'b11;
        dispatch_rd_arch_i     = {5'(base + 1), 5'(base)};
        dispatch_rd_phys_i     = {6'(base + 33), 6'(base + 32)};
        dispatch_rd_old_phys_i = {6'(base + 11), 6'(base + 10)};
    endtask

    // One clock: drive inputs, advance model, check everything after the edge
    task automatic step(input bit r, input logic [1:0] dv, input logic [1:0] cv,
                        input logic [7:0] ct, input logic [1:0] cm);
        logic [1:0] e_cv;
        bit   e_hr [CW];
        int   e_arch [CW];
        int   e_phys [CW];
        int   e_old [CW];
        bit   fl;
        int   ftag;
        int   n;
        bit   stop;
        bit   ready;
        rst              = r;
        dispatch_valid_i = dv;
        cdb_valid_i      = cv;
        cdb_tag_i        = ct;
        cdb_mispredict_i = cm;
        e_cv = '0; fl = 0; ftag = 0; n = 0; stop = 0;
        for (int j = 0; j < CW; j++) begin
            e_hr[j] = 0; e_arch[j] = 0; e_phys[j] = 0; e_old[j] = 0;
        end
        if (r) begin
            mq.delete();
            m_tail = 0;
        end else begin
            ready = (mq.size() + DW <= DEPTH);
            for (int j = 0; j < CW; j++) begin
                if (!stop && j < mq.size() && mq[j].done) begin
                    e_cv[j] = 1'b1; e_hr[j] = mq[j].has_rd; e_arch[j] = mq[j].arch;
                    e_phys[j] = mq[j].phys; e_old[j] = mq[j].old;
                    n++;
                    if (mq[j].mis) begin fl = 1; ftag = mq[j].tag; stop = 1; end
                end else begin
                    stop = 1;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (cv[p]) begin
                    foreach (mq[i]) begin
                        if (mq[i].tag == int'(ct[p*TW +: TW])) begin
                            mq[i].done = 1;
                            mq[i].mis  = mq[i].mis | cm[p];
                        end
                    end
                end
            end
            if (fl) begin
                mq.delete();
                m_tail = (ftag + 1) % DEPTH;
            end else begin
                for (int j = 0; j < n; j++) void'(mq.pop_front());
                if (ready && dv != 2'b00) begin
                    for (int k = 0; k < DW; k++) begin
                        if (dv[k]) begin
                            ent_t e;
                            e.tag    = m_tail;
                            e.has_rd = dispatch_has_rd_i[k];
                            e.arch   = int'(dispatch_rd_arch_i[k*5 +: 5]);
                            e.phys   = int'(dispatch_rd_phys_i[k*6 +: 6]);
                            e.old    = int'(dispatch_rd_old_phys_i[k*6 +: 6]);
                            e.done   = 0;
                            e.mis    = 0;
                            mq.push_back(e);
                            m_tail = (m_tail + 1) % DEPTH;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("commit_valid", 32'(commit_valid_o), 32'(e_cv));
        for (int j = 0; j < CW; j++) begin
            if (e_cv[j]) begin
                check("commit_has_rd", 32'(commit_has_rd_o[j]), 32'(e_hr[j]));
                check("commit_rd_arch", 32'(commit_rd_arch_o[j*5 +: 5]), 32'(e_arch[j]));
                check("commit_rd_phys", 32'(commit_rd_phys_o[j*6 +: 6]), 32'(e_phys[j]));
                if (e_hr[j]) check("commit_old_preg", 32'(commit_old_preg_o[j*6 +: 6]), 32'(e_old[j]));
            end
        end
        check("flush", 32'(flush_o), 32'(fl));
        if (fl) check("flush_tag", 32'(flush_tag_o), 32'(ftag));
        check("count", 32'(rob_count_o), 32'(mq.size()));
        check("empty", 32'(rob_empty_o), 32'(mq.size() == 0));
        check("ready", 32'(dispatch_ready_o), 32'(mq.size() + DW <= DEPTH));
        check("alloc_tag", 32'(alloc_tag_o), 32'({4'((m_tail + 1) % DEPTH), 4'(m_tail)}));
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 2'b00, 2'b00, 8'h00, 2'b00);
    endtask

    task automatic do_reset();
        step(1, 2'b00, 2'b00, 8'h00, 2'b00);
        step(1, 2'b00, 2'b00, 8'h00, 2'b00);
    endtask

    initial begin
        logic [1:0] dv, cv, cm;
        logic [7:0] ct;
        int pick;
        rst = 1'b1;
        dispatch_valid_i = '0; cdb_valid_i = '0; cdb_tag_i = '0; cdb_mispredict_i = '0;
        pay(0);
        @(negedge clk);

        // Reset state, basic two-lane dispatch and same-cycle completion
        do_reset();
        check("rst_commit_valid", 32'(commit_valid_o), 0);
        check("rst_commit_old", 32'(commit_old_preg_o), 0);
        check("rst_commit_phys", 32'(commit_rd_phys_o), 0);
        check("rst_flush_tag", 32'(flush_tag_o), 0);
        check("rst_empty", 32'(rob_empty_o), 1);
        check("rst_ready", 32'(dispatch_ready_o), 1);
        check("rst_alloc", 32'(alloc_tag_o), 32'h10);
        pay(0);
        step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        check("t1_count", 32'(rob_count_o), 2);
        step(0, 2'b00, 2'b11, 8'h10, 2'b00);
        idle();
        check("t1_commit_valid", 32'(commit_valid_o), 3);
        check("t1_commit_old", 32'(commit_old_preg_o), 32'({6'd11, 6'd10}));
        check("t1_count0", 32'(rob_count_o), 0);

        // Out-of-order completion, in-order retirement
        do_reset();
        pay(0); step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        pay(2); step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        step(0, 2'b00, 2'b01, 8'h03, 2'b00);
        step(0, 2'b00, 2'b01, 8'h02, 2'b00);
        step(0, 2'b00, 2'b01, 8'h01, 2'b00);
        idle();
        check("t2_no_commit", 32'(commit_valid_o), 0);
        step(0, 2'b00, 2'b01, 8'h00, 2'b00);
        idle();
        check("t2_commit01", 32'(commit_valid_o), 3);
        check("t2_phys01", 32'(commit_rd_phys_o), 32'({6'd33, 6'd32}));
        idle();
        check("t2_commit23", 32'(commit_valid_o), 3);
        check("t2_phys23", 32'(commit_rd_phys_o), 32'({6'd35, 6'd34}));

        // Mispredict on tag 2 squashes 3..5
        do_reset();
        for (int i = 0; i < 3; i++) begin pay(2 * i); step(0, 2'b11, 2'b00, 8'h00, 2'b00); end
        step(0, 2'b00, 2'b11, 8'h10, 2'b00);
        step(0, 2'b00, 2'b11, 8'h32, 2'b01);
        check("t3_commit01", 32'(commit_valid_o), 3);
        step(0, 2'b00, 2'b11, 8'h54, 2'b00);
        check("t3_commit2", 32'(commit_valid_o), 1);
        check("t3_flush", 32'(flush_o), 1);
        check("t3_flush_tag", 32'(flush_tag_o), 2);
        check("t3_empty", 32'(rob_empty_o), 1);
        check("t3_alloc", 32'(alloc_tag_o), 32'h43);
        idle();
        check("t3_flush_drop", 32'(flush_o), 0);
        idle();
        check("t3_no_commit", 32'(commit_valid_o), 0);

        // Full ROB blocks dispatch; ready returns only after retirement
        do_reset();
        for (int i = 0; i < 8; i++) begin pay(2 * i); step(0, 2'b11, 2'b00, 8'h00, 2'b00); end
        check("t4_full", 32'(rob_count_o), 16);
        check("t4_not_ready", 32'(dispatch_ready_o), 0);
        step(0, 2'b11, 2'b11, 8'h10, 2'b00);
        check("t4_still_full", 32'(rob_count_o), 16);
        step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        check("t4_count14", 32'(rob_count_o), 14);
        check("t4_ready", 32'(dispatch_ready_o), 1);
        step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        check("t4_refill", 32'(rob_count_o), 16);

        // Wrap-around: bring head and tail to 15, dispatch across the wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            pay(i);
            step(0, 2'b01, (i > 0) ? 2'b01 : 2'b00, 8'(i - 1), 2'b00);
        end
        step(0, 2'b00, 2'b01, 8'h0E, 2'b00);
        for (int i = 0; i < 3; i++) idle();
        check("t5_empty", 32'(rob_empty_o), 1);
        check("t5_alloc_wrap", 32'(alloc_tag_o), 32'h0F);
        pay(40); step(0, 2'b11, 2'b00, 8'h00, 2'b00);
        step(0, 2'b00, 2'b11, 8'h0F, 2'b00);
        idle();
        check("t5_commit_both", 32'(commit_valid_o), 3);
        check("t5_alloc_head1", 32'(alloc_tag_o), 32'h21);

        // Reset mid-operation, then stale completions to old tags
        do_reset();
        for (int i = 0; i < 3; i++) begin pay(2 * i); step(0, 2'b11, 2'b00, 8'h00, 2'b00); end
        pay(6); step(0, 2'b01, 2'b00, 8'h00, 2'b00);
        check("t6_count7", 32'(rob_count_o), 7);
        step(1, 2'b00, 2'b11, 8'h10, 2'b00);
        check("t6_rst_count", 32'(rob_count_o), 0);
        check("t6_rst_empty", 32'(rob_empty_o), 1);
        step(0, 2'b00, 2'b11, 8'h10, 2'b00);
        idle();
        check("t6_no_commit", 32'(commit_valid_o), 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pick = int'($urandom_range(0, 2));
            dv = (pick == 0) ? 2'b00 : ((pick == 1) ? 2'b01 : 2'b11);
            dispatch_has_rd_i      = 2'($urandom);
            dispatch_rd_arch_i     = 10'($urandom);
            dispatch_rd_phys_i     = 12'($urandom);
            dispatch_rd_old_phys_i = 12'($urandom);
            cv = '0; cm = '0; ct = '0;
            for (int p = 0; p < NP; p++) begin
                cv[p] = 1'($urandom);
                cm[p] = ($urandom_range(0, 11) == 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    ct[p*TW +: TW] = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    ct[p*TW +: TW] = 4'($urandom);
            end
            step(0, dv, cv, ct, cm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised successor to the single-issue reorder buffer.
- Supports DISP_W-wide dispatch, COMMIT_W-wide in-order retirement and CDB_PORTS completion ports.
- On retirement of a mispredicted entry, it squashes all younger entries and raises a flush.
- Sits between rename/dispatch and the free list / recovery logic: retiring entries release rd_old_phys; flush triggers front-end redirect and rename-map restore.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of 2, >= max(DISP_W, COMMIT_W).
- ROB_TAG_W, $clog2(ROB_DEPTH), entry index (tag) width.
- PREG_W, 6, physical register index width.
- AREG_W, 5, architectural register index width.
- DISP_W, 2, dispatch lanes per cycle.
- COMMIT_W, 2, maximum retirements per cycle.
- CDB_PORTS, 2, completion broadcast ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dispatch_valid_i  in  DISP_W  per-lane dispatch request; lanes packed from lane 0.
- dispatch_has_rd_i  in  DISP_W  lane writes a destination register.
- dispatch_rd_arch_i  in  DISP_W*AREG_W  architectural destination per lane.
- dispatch_rd_phys_i  in  DISP_W*PREG_W  newly allocated physical destination per lane.
- dispatch_rd_old_phys_i  in  DISP_W*PREG_W  previous mapping per lane.
- dispatch_ready_o  out  1  high when free entries >= DISP_W.
- alloc_tag_o  out  DISP_W*ROB_TAG_W  tag for lane k = tail_ptr + k (mod depth).
- cdb_valid_i  in  CDB_PORTS  completion valid per port.
- cdb_tag_i  in  CDB_PORTS*ROB_TAG_W  completing tag per port.
- cdb_mispredict_i  in  CDB_PORTS  completing branch was mispredicted.
- commit_valid_o  out  COMMIT_W  registered retire valid per slot; packed from slot 0.
- commit_has_rd_o  out  COMMIT_W  retired entry had a destination register.
- commit_rd_arch_o  out  COMMIT_W*AREG_W  retired entry's architectural destination.
- commit_rd_phys_o  out  COMMIT_W*PREG_W  retired entry's physical destination.
- commit_old_preg_o  out  COMMIT_W*PREG_W  physical register to free (meaningful only when has_rd).
- flush_o  out  1  one-cycle pulse: squash all younger work.
- flush_tag_o  out  ROB_TAG_W  tag of the mispredicted entry that caused the flush.
- rob_empty_o  out  1  count == 0.
- rob_count_o  out  ROB_TAG_W+1  occupied entries.

Behaviour:
- Reset: head = tail = count = 0; every entry's valid, done and mispred bits cleared.
- Reset values of outputs: commit_valid_o = 0, flush_o = 0, all commit_* data = 0, flush_tag_o = 0, rob_empty_o = 1, dispatch_ready_o = 1.
- Reset overrides any dispatch, CDB or commit activity in the same cycle; there is no partial state.
- Dispatch acceptance: all-or-nothing. Accepted iff dispatch_ready_o && |dispatch_valid_i.
- On acceptance, lane k writes entry tail+k with valid=1, done=0, mispred=0; tail advances by popcount(dispatch_valid_i).
- A non-packed valid pattern (e.g. 2'b10) is illegal; the block asserts in simulation.
- Completion: each cdb port with valid=1 sets done on its tag. cdb_mispredict_i also sets mispred.
- A CDB write to an invalid entry is ignored.
- Two ports targeting the same tag: done set once, mispred is the OR of the two.
- Commit selection, combinational from current array state: scan slots j = 0..COMMIT_W-1 starting at head.
- Slot j retires iff j < count, entry valid && done, and all earlier slots retired.
- Scanning stops after the first retiring entry with mispred = 1.
- Results are registered: commit_* outputs appear the cycle after selection.
- Latency: cdb_valid_i on the head tag sampled at edge E means commit_valid_o[0] = 1 during the cycle after edge E+1.
- Flush: when a retiring entry has mispred = 1, then at the same edge as its commit_* registration:
  - flush_o <= 1 and flush_tag_o <= its tag;
  - all entries are cleared invalid;
  - head <= tag+1, tail <= tag+1, count <= 0;
  - any dispatch accepted in that cycle is discarded, with tail and count not incremented.
- flush_o deasserts the following cycle unless another flush occurs, which is impossible since the ROB is empty.
- Count update: count_next = count + accepted - retired; simultaneous dispatch and commit are exact.
- dispatch_ready_o uses the current count only, with no commit bypass.
- Full and empty:
  - With count = ROB_DEPTH, dispatch is blocked and CDB and commit still operate.
  - With count = 0, nothing commits.
  - A stale done bit on an invalid entry never commits.
- Wrap-around: pointers are ROB_TAG_W bits and wrap modulo ROB_DEPTH; tags for lanes straddling the wrap are contiguous mod depth.
- Outputs are combinational from state: rob_empty_o, rob_count_o, dispatch_ready_o, alloc_tag_o.

Test Plan:
- Reset then dispatch 2 lanes (rd_old_phys 10, 11) -> alloc_tag_o = {1,0}, rob_count_o = 2; cdb tags 0,1 same cycle -> two cycles later commit_valid_o = 2'b11, commit_old_preg_o = {11,10}, count = 0.
- Out-of-order completion: dispatch tags 0-3, CDB 3, 2, 1 -> no commit; CDB 0 -> commits 0,1 next, then 2,3 the following cycle.
- Mispredict: dispatch 0-5, CDB all, with tag 2 mispredicted -> retire {0,1}, then {2} with flush_o = 1 and flush_tag_o = 2; head = tail = 3, rob_empty_o = 1; tags 3-5 never commit.
- Full: 8 dispatches of 2 lanes with depth 16 -> count = 16, dispatch_ready_o = 0; retire 2 with concurrent dispatch held -> ready = 1 next cycle; count never exceeds 16.
- Wrap: head = tail = 15, dispatch 2 -> alloc_tag_o = {0,15}; complete both -> both commit in one cycle, head = 1.
- Reset mid-operation: count = 7 with pending CDB -> rst pulse clears all; a CDB arriving after reset to old tags produces no commit.
